// File: rtl/fwd_scoreboard.sv
// Hazard and forwarding controller: per-stage scoreboard of in-flight destinations
// with Tnew countdown, operand resolution against it, and the Tuse/Tnew D-stage stall.
module fwd_scoreboard #(
   parameter int WIDTH = 32,
   parameter int REGW  = 5,
   parameter int NSRC  = 2,
   parameter int DEPTH = 3,
   parameter int TW    = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NSRC*REGW-1:0]   src_addr,
   input  logic [NSRC*TW-1:0]     src_tuse,
   input  logic [NSRC*WIDTH-1:0]  src_grf,
   input  logic                   iss_valid,
   input  logic [REGW-1:0]        iss_dst,
   input  logic [TW-1:0]          iss_tnew,
   input  logic [DEPTH*WIDTH-1:0] stg_data,
   output logic [NSRC*WIDTH-1:0]  op_data,
   output logic [NSRC*2-1:0]      op_sel,
   output logic [NSRC-1:0]        op_ready,
   output logic                   stall
);

   localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0] v_q;
   logic [DEPTH-1:0] v_d;
   logic [REGW-1:0]  dst_q  [DEPTH];
   logic [REGW-1:0]  dst_d  [DEPTH];
   logic [TW-1:0]    tnew_q [DEPTH];
   logic [TW-1:0]    tnew_d [DEPTH];

   logic [NSRC-1:0]  hit_s;
   logic [IDXW-1:0]  hit_idx_s  [NSRC];
   logic [TW-1:0]    hit_tnew_s [NSRC];
   logic [NSRC-1:0]  late_s;
   logic             stall_s;

   function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
      logic [TW-1:0] r;
      if (t == {TW{1'b0}}) begin
         r = {TW{1'b0}};
      end else begin
         r = t - TW'(1);
      end
      return r;
   endfunction

   // Youngest-match search: scanning old to young lets the youngest overwrite.
   always_comb begin
      for (int k = 0; k < NSRC; k++) begin
         hit_s[k]      = 1'b0;
         hit_idx_s[k]  = {IDXW{1'b0}};
         hit_tnew_s[k] = {TW{1'b0}};
         for (int i = DEPTH - 1; i >= 0; i--) begin
            if (v_q[i] && (dst_q[i] == src_addr[k*REGW +: REGW]) &&
                (src_addr[k*REGW +: REGW] != {REGW{1'b0}})) begin
               hit_s[k]      = 1'b1;
               hit_idx_s[k]  = IDXW'(i);
               hit_tnew_s[k] = tnew_q[i];
            end else begin
               hit_s[k]      = hit_s[k];
               hit_idx_s[k]  = hit_idx_s[k];
               hit_tnew_s[k] = hit_tnew_s[k];
            end
         end
      end
   end

   // Operand select/data/ready and per-operand lateness.
   always_comb begin
      op_data  = {(NSRC*WIDTH){1'b0}};
      op_sel   = {(NSRC*2){1'b0}};
      op_ready = {NSRC{1'b0}};
      late_s   = {NSRC{1'b0}};
      for (int k = 0; k < NSRC; k++) begin
         if (hit_s[k]) begin
            op_sel[k*2 +: 2]          = 2'(hit_idx_s[k]) + 2'd1;
            op_data[k*WIDTH +: WIDTH] = stg_data[int'(hit_idx_s[k])*WIDTH +: WIDTH];
            op_ready[k]               = (hit_tnew_s[k] == {TW{1'b0}});
            // A producer later than this operand's use point cannot be covered downstream.
            late_s[k]                 = (hit_tnew_s[k] > src_tuse[k*TW +: TW]);
         end else begin
            op_sel[k*2 +: 2]          = 2'd0;
            op_data[k*WIDTH +: WIDTH] = src_grf[k*WIDTH +: WIDTH];
            op_ready[k]               = 1'b1;
            late_s[k]                 = 1'b0;
         end
      end
      stall_s = |late_s;
   end

   assign stall = stall_s;

   // Next scoreboard: E loads the issue or a bubble, older stages shift with countdown.
   always_comb begin
      if (stall_s) begin
         v_d[0]    = 1'b0;
         dst_d[0]  = {REGW{1'b0}};
         tnew_d[0] = {TW{1'b0}};
      end else begin
         v_d[0]    = iss_valid && (iss_dst != {REGW{1'b0}});
         dst_d[0]  = iss_dst;
         tnew_d[0] = iss_tnew;
      end
      for (int i = 1; i < DEPTH; i++) begin
         v_d[i]    = v_q[i-1];
         dst_d[i]  = dst_q[i-1];
         tnew_d[i] = sat_dec(tnew_q[i-1]);
      end
   end

   // Scoreboard state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         v_q <= {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            dst_q[i]  <= {REGW{1'b0}};
            tnew_q[i] <= {TW{1'b0}};
         end
      end else begin
         v_q <= v_d;
         for (int i = 0; i < DEPTH; i++) begin
            dst_q[i]  <= dst_d[i];
            tnew_q[i] <= tnew_d[i];
         end
      end
   end

   fwd_scoreboard_chk #(
      .NSRC  (NSRC),
      .DEPTH (DEPTH)
   ) u_chk (
      .clk      (clk),
      .reset    (reset),
      .stall    (stall_s),
      .v        (v_q),
      .op_sel   (op_sel),
      .op_ready (op_ready)
   );

endmodule

// Invariants of the scoreboard: bubbles on stall, empty after reset, sane selects.
module fwd_scoreboard_chk #(
   parameter int NSRC  = 2,
   parameter int DEPTH = 3
) (
   input logic              clk,
   input logic              reset,
   input logic              stall,
   input logic [DEPTH-1:0]  v,
   input logic [NSRC*2-1:0] op_sel,
   input logic [NSRC-1:0]   op_ready
);

   a_reset_empty: assert property (@(posedge clk) $past(reset) |-> (v == {DEPTH{1'b0}}));

   a_stall_bubble: assert property (@(posedge clk) ($past(stall) && !$past(reset)) |-> !v[0]);

   a_stall_not_ready: assert property (@(posedge clk) stall |-> (op_ready != {NSRC{1'b1}}));

   for (genvar k = 0; k < NSRC; k++) begin : g_sel
      a_sel_range: assert property (@(posedge clk) int'(op_sel[k*2 +: 2]) <= DEPTH);
   end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed hazard scenarios plus a randomized
// run against a producer-list reference model.
module tb_fwd_scoreboard;

   localparam int WIDTH = 32;
   localparam int REGW  = 5;
   localparam int NSRC  = 2;
   localparam int DEPTH = 3;
   localparam int TW    = 2;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [NSRC*REGW-1:0]   src_addr;
   logic [NSRC*TW-1:0]     src_tuse;
   logic [NSRC*WIDTH-1:0]  src_grf;
   logic                   iss_valid;
   logic [REGW-1:0]        iss_dst;
   logic [TW-1:0]          iss_tnew;
   logic [DEPTH*WIDTH-1:0] stg_data;
   logic [NSRC*WIDTH-1:0]  op_data;
   logic [NSRC*2-1:0]      op_sel;
   logic [NSRC-1:0]        op_ready;
   logic                   stall;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [REGW-1:0] dst;
      int              enter;
      int              avail;
   } prod_t;
   prod_t q[$];

   fwd_scoreboard #(
      .WIDTH (WIDTH), .REGW (REGW), .NSRC (NSRC), .DEPTH (DEPTH), .TW (TW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .src_addr  (src_addr),
      .src_tuse  (src_tuse),
      .src_grf   (src_grf),
      .iss_valid (iss_valid),
      .iss_dst   (iss_dst),
      .iss_tnew  (iss_tnew),
      .stg_data  (stg_data),
      .op_data   (op_data),
      .op_sel    (op_sel),
      .op_ready  (op_ready),
      .stall     (stall)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] sel_of(input int k);
      return op_sel[k*2 +: 2];
   endfunction

   function automatic logic [WIDTH-1:0] data_of(input int k);
      return op_data[k*WIDTH +: WIDTH];
   endfunction

   task automatic set_src(input int k, input logic [REGW-1:0] a, input logic [TW-1:0] tu,
                          input logic [WIDTH-1:0] g);
      src_addr[k*REGW +: REGW]   = a;
      src_tuse[k*TW +: TW]       = tu;
      src_grf[k*WIDTH +: WIDTH]  = g;
   endtask

   task automatic set_stg(input int i, input logic [WIDTH-1:0] d);
      stg_data[i*WIDTH +: WIDTH] = d;
   endtask

   task automatic issue(input logic v, input logic [REGW-1:0] d, input logic [TW-1:0] t);
      iss_valid = v;
      iss_dst   = d;
      iss_tnew  = t;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      issue(1'b0, 5'd0, 2'd0);
      set_src(0, 5'd0, 2'd0, 32'd0);
      set_src(1, 5'd0, 2'd0, 32'd0);
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      issue(1'b1, 5'd7, 2'd2);
      set_src(0, 5'd5, 2'd0, 32'h11);
      set_src(1, 5'd6, 2'd0, 32'h22);
      stg_data = {32'hC3C3_0003, 32'hB2B2_0002, 32'hA1A1_0001};
      tick();
      reset = 1'b0;
      issue(1'b0, 5'd0, 2'd0);
      #2;
      checks++; if (op_data !== {32'h22, 32'h11}) begin errors++;
         $display("FAIL reset_data got %0h exp %0h", op_data, {32'h22, 32'h11}); end
      checks++; if (op_sel !== 4'd0) begin errors++;
         $display("FAIL reset_sel got %0h exp 0", op_sel); end
      checks++; if (op_ready !== 2'b11) begin errors++;
         $display("FAIL reset_ready got %0b exp 11", op_ready); end
      checks++; if (stall !== 1'b0) begin errors++;
         $display("FAIL reset_stall got %0b exp 0", stall); end
      set_src(1, 5'd7, 2'd0, 32'h77);
      #1;
      checks++; if (sel_of(1) !== 2'd0 || data_of(1) !== 32'h77) begin errors++;
         $display("FAIL reset_over_issue sel %0d data %0h exp sel 0 data 77", sel_of(1), data_of(1)); end
   endtask

   task automatic test_alu_forward();
      do_reset();
      issue(1'b1, 5'd8, 2'd1);
      tick();
      issue(1'b0, 5'd0, 2'd0);
      set_src(0, 5'd8, 2'd1, 32'h1234);
      set_src(1, 5'd5, 2'd2, 32'h55);
      stg_data = {32'h0, 32'h0, 32'hE0E0};
      #2;
      checks++; if (stall !== 1'b0) begin errors++;
         $display("FAIL alu_e_stall got %0b exp 0", stall); end
      checks++; if (sel_of(0) !== 2'd1 || op_ready[0] !== 1'b0 || data_of(0) !== 32'hE0E0) begin errors++;
         $display("FAIL alu_e_op0 sel %0d rdy %0b data %0h exp 1 0 e0e0", sel_of(0), op_ready[0], data_of(0)); end
      checks++; if (sel_of(1) !== 2'd0 || op_ready[1] !== 1'b1 || data_of(1) !== 32'h55) begin errors++;
         $display("FAIL alu_e_op1 sel %0d rdy %0b data %0h exp 0 1 55", sel_of(1), op_ready[1], data_of(1)); end
      tick();
      set_stg(1, 32'hABCD);
      #2;
      checks++; if (sel_of(0) !== 2'd2 || op_ready[0] !== 1'b1 || data_of(0) !== 32'hABCD) begin errors++;
         $display("FAIL alu_m_op0 sel %0d rdy %0b data %0h exp 2 1 abcd", sel_of(0), op_ready[0], data_of(0)); end
      checks++; if (stall !== 1'b0) begin errors++;
         $display("FAIL alu_m_stall got %0b exp 0", stall); end
   endtask

   task automatic test_load_use();
      do_reset();
      issue(1'b1, 5'd9, 2'd2);
      tick();
      issue(1'b1, 5'd10, 2'd1);
      set_src(0, 5'd9, 2'd1, 32'h99);
      #2;
      checks++; if (stall !== 1'b1 || op_ready[0] !== 1'b0) begin errors++;
         $display("FAIL lu_stall stall %0b rdy %0b exp 1 0", stall, op_ready[0]); end
      tick();
      set_src(1, 5'd10, 2'd3, 32'hA0);
      #2;
      checks++; if (stall !== 1'b0 || op_ready[0] !== 1'b0 || sel_of(0) !== 2'd2) begin errors++;
         $display("FAIL lu_m stall %0b rdy %0b sel %0d exp 0 0 2", stall, op_ready[0], sel_of(0)); end
      checks++; if (sel_of(1) !== 2'd0 || data_of(1) !== 32'hA0) begin errors++;
         $display("FAIL lu_bubble sel %0d data %0h exp 0 a0", sel_of(1), data_of(1)); end
      tick();
      issue(1'b0, 5'd0, 2'd0);
      #2;
      checks++; if (sel_of(1) !== 2'd1 || op_ready[1] !== 1'b0 || stall !== 1'b0) begin errors++;
         $display("FAIL lu_reissue sel %0d rdy %0b stall %0b exp 1 0 0", sel_of(1), op_ready[1], stall); end
      checks++; if (sel_of(0) !== 2'd3 || op_ready[0] !== 1'b1) begin errors++;
         $display("FAIL lu_w sel %0d rdy %0b exp 3 1", sel_of(0), op_ready[0]); end
   endtask

   task automatic test_branch();
      logic [WIDTH-1:0] w;
      do_reset();
      issue(1'b1, 5'd9, 2'd2);
      tick();
      issue(1'b0, 5'd0, 2'd0);
      set_src(0, 5'd9, 2'd0, 32'h1);
      for (int c = 0; c < 2; c++) begin
         #2;
         checks++; if (stall !== 1'b1) begin errors++;
            $display("FAIL br_stall cycle %0d got %0b exp 1", c, stall); end
         tick();
      end
      w = $urandom;
      set_stg(2, w);
      #2;
      checks++; if (stall !== 1'b0 || sel_of(0) !== 2'd3 || data_of(0) !== w || op_ready[0] !== 1'b1) begin errors++;
         $display("FAIL br_w stall %0b sel %0d data %0h rdy %0b exp 0 3 %0h 1", stall, sel_of(0), data_of(0), op_ready[0], w); end
   endtask

   task automatic test_zero_reg();
      logic [WIDTH-1:0] g0;
      logic [WIDTH-1:0] g1;
      do_reset();
      issue(1'b1, 5'd0, 2'd2);
      tick();
      issue(1'b0, 5'd0, 2'd0);
      for (int c = 0; c < 2; c++) begin
         g0 = $urandom;
         g1 = $urandom;
         set_src(0, 5'd0, 2'd0, g0);
         set_src(1, 5'd0, 2'd3, g1);
         #2;
         checks++; if (stall !== 1'b0 || op_sel !== 4'd0 || op_data !== {g1, g0} || op_ready !== 2'b11) begin errors++;
            $display("FAIL zero_reg cycle %0d stall %0b sel %0h data %0h exp 0 0 %0h", c, stall, op_sel, op_data, {g1, g0}); end
         tick();
      end
   endtask

   task automatic test_youngest();
      do_reset();
      issue(1'b1, 5'd4, 2'd0);
      tick();
      issue(1'b1, 5'd7, 2'd3);
      tick();
      issue(1'b1, 5'd4, 2'd0);
      tick();
      issue(1'b0, 5'd0, 2'd0);
      set_src(0, 5'd4, 2'd0, 32'hDEAD);
      set_src(1, 5'd4, 2'd3, 32'hBEEF);
      stg_data = {32'h2, 32'h77, 32'h1};
      #2;
      checks++; if (sel_of(0) !== 2'd1 || data_of(0) !== 32'h1 || op_ready[0] !== 1'b1) begin errors++;
         $display("FAIL youngest_op0 sel %0d data %0h rdy %0b exp 1 1 1", sel_of(0), data_of(0), op_ready[0]); end
      checks++; if (sel_of(1) !== 2'd1 || data_of(1) !== 32'h1 || stall !== 1'b0) begin errors++;
         $display("FAIL youngest_op1 sel %0d data %0h stall %0b exp 1 1 0", sel_of(1), data_of(1), stall); end
   endtask

   task automatic test_independent_tuse();
      do_reset();
      issue(1'b1, 5'd12, 2'd2);
      tick();
      issue(1'b0, 5'd0, 2'd0);
      set_src(0, 5'd12, 2'd1, 32'h0);
      set_src(1, 5'd12, 2'd3, 32'h0);
      set_stg(0, 32'hC);
      #2;
      checks++; if (stall !== 1'b1 || op_ready !== 2'b00) begin errors++;
         $display("FAIL indep_tuse stall %0b rdy %0b exp 1 00", stall, op_ready); end
      checks++; if (sel_of(1) !== 2'd1 || data_of(1) !== 32'hC) begin errors++;
         $display("FAIL indep_op1 sel %0d data %0h exp 1 c", sel_of(1), data_of(1)); end
   endtask

   // Reference: list of in-flight producers with the cycle they entered E and the
   // cycle their result exists; stage = age, remaining Tnew = time to availability.
   task automatic test_random(input int n);
      int cyc;
      logic exp_stall;
      logic found;
      int age;
      int rem;
      logic [REGW-1:0] a;
      int tu;
      do_reset();
      q.delete();
      cyc = 0;
      for (int c = 0; c < n; c++) begin
         reset = ($urandom_range(49) == 0);
         issue(1'($urandom_range(1)), 5'($urandom_range(7)), 2'($urandom_range(3)));
         for (int k = 0; k < NSRC; k++) set_src(k, 5'($urandom_range(7)), 2'($urandom_range(3)), $urandom);
         for (int i = 0; i < DEPTH; i++) set_stg(i, $urandom);
         #2;
         while (q.size() > 0 && (cyc - q[0].enter) >= DEPTH) void'(q.pop_front());
         exp_stall = 1'b0;
         for (int k = 0; k < NSRC; k++) begin
            a = src_addr[k*REGW +: REGW];
            tu = int'(src_tuse[k*TW +: TW]);
            found = 1'b0; age = 0; rem = 0;
            foreach (q[j]) begin
               if (q[j].dst == a && a != 5'd0) begin
                  found = 1'b1;
                  age = cyc - q[j].enter;
                  rem = (q[j].avail > cyc) ? q[j].avail - cyc : 0;
               end
            end
            if (!found) begin
               checks++; if (sel_of(k) !== 2'd0 || data_of(k) !== src_grf[k*WIDTH +: WIDTH] || op_ready[k] !== 1'b1) begin errors++;
                  $display("FAIL rnd_grf c %0d op %0d sel %0d data %0h rdy %0b exp 0 %0h 1", c, k, sel_of(k), data_of(k), op_ready[k], src_grf[k*WIDTH +: WIDTH]); end
            end else if (rem <= tu) begin
               checks++; if (int'(sel_of(k)) != age + 1 || data_of(k) !== stg_data[age*WIDTH +: WIDTH] || op_ready[k] !== (rem == 0)) begin errors++;
                  $display("FAIL rnd_fwd c %0d op %0d sel %0d data %0h rdy %0b exp %0d %0h %0b", c, k, sel_of(k), data_of(k), op_ready[k], age + 1, stg_data[age*WIDTH +: WIDTH], rem == 0); end
            end else begin
               exp_stall = 1'b1;
               checks++; if (op_ready[k] !== 1'b0) begin errors++;
                  $display("FAIL rnd_late c %0d op %0d rdy %0b exp 0", c, k, op_ready[k]); end
            end
         end
         checks++; if (stall !== exp_stall) begin errors++;
            $display("FAIL rnd_stall c %0d got %0b exp %0b", c, stall, exp_stall); end
         tick();
         if (reset) q.delete();
         else if (!exp_stall && iss_valid && iss_dst != 5'd0) q.push_back('{iss_dst, cyc + 1, cyc + 1 + int'(iss_tnew)});
         cyc++;
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      iss_valid = 1'b0; iss_dst = 5'd0; iss_tnew = 2'd0;
      src_addr = '0; src_tuse = '0; src_grf = '0; stg_data = '0;
      test_reset();
      test_alu_forward();
      test_load_use();
      test_branch();
      test_zero_reg();
      test_youngest();
      test_independent_tuse();
      test_random(600);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
